// File: rtl/fb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : fb_arbiter_if
// Brief   : Bundles the scanout, drawing-port, clear and RAM-side signals of
//           the framebuffer arbiter.
// Revision: 1.0 - initial release
// ============================================================================
interface fb_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
);
  logic              scan_req;
  logic [ADDR_W-1:0] scan_addr;
  logic [DATA_W-1:0] scan_data;
  logic              scan_valid;

  logic              w0_valid, w0_ready;
  logic [ADDR_W-1:0] w0_addr;
  logic [DATA_W-1:0] w0_data, w0_mask;
  logic              w1_valid, w1_ready;
  logic [ADDR_W-1:0] w1_addr;
  logic [DATA_W-1:0] w1_data, w1_mask;

  logic              clear_start;
  logic [DATA_W-1:0] clear_value;
  logic              clear_busy;
  logic              addr_err;

  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_wmask;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  scan_req, scan_addr,
    input  w0_valid, w0_addr, w0_data, w0_mask,
    input  w1_valid, w1_addr, w1_data, w1_mask,
    input  clear_start, clear_value, mem_rdata,
    output scan_data, scan_valid, w0_ready, w1_ready, clear_busy, addr_err,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_wmask
  );

  modport master (
    output scan_req, scan_addr,
    output w0_valid, w0_addr, w0_data, w0_mask,
    output w1_valid, w1_addr, w1_data, w1_mask,
    output clear_start, clear_value, mem_rdata,
    input  scan_data, scan_valid, w0_ready, w1_ready, clear_busy, addr_err,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_wmask
  );
endinterface
`default_nettype wire

// File: rtl/fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : fb_arbiter
// Brief   : Single-port framebuffer RAM arbiter: scanout first, optional clear
//           engine (FB_ARB_CLEAR_EN), then two round-robin drawing writers.
// Revision: 1.0 - initial release
// ============================================================================
module fb_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16,
  parameter int WORDS  = 4800
) (
  input  logic        clk,
  input  logic        rst,
  fb_arbiter_if.slave bus
);
  localparam logic [ADDR_W-1:0] c_words = ADDR_W'(WORDS);
  localparam logic [ADDR_W-1:0] c_last  = ADDR_W'(WORDS - 1);

  logic              w_idle, w_clearing;
  logic [ADDR_W-1:0] w_clr_addr;
  logic [DATA_W-1:0] w_clr_data;

`ifdef FB_ARB_CLEAR_EN
  typedef enum logic [0:0] {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0] r_clr_val, w_clr_val_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_clr_val <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_clr_val <= w_clr_val_nxt;
    end
  end

  // The counter only moves on cycles the scanout leaves free.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_clr_val_nxt = r_clr_val;
    case (r_state)
      IDLE: begin
        if (bus.clear_start) begin
          w_state_nxt   = CLEAR;
          w_cnt_nxt     = '0;
          w_clr_val_nxt = bus.clear_value;
        end
      end
      CLEAR: begin
        if (!bus.scan_req) begin
          if (r_cnt == c_last) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + ADDR_W'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_idle         = (r_state == IDLE);
  assign w_clearing     = (r_state == CLEAR);
  assign w_clr_addr     = r_cnt;
  assign w_clr_data     = r_clr_val;
  assign bus.clear_busy = w_clearing;
`else
  logic w_unused_clear;
  assign w_unused_clear = ^{bus.clear_start, bus.clear_value};
  assign w_idle         = 1'b1;
  assign w_clearing     = 1'b0;
  assign w_clr_addr     = '0;
  assign w_clr_data     = '0;
  assign bus.clear_busy = 1'b0;
`endif

  logic              r_rr, r_addr_err, r_scan_p1, r_scan_valid;
  logic              r_mem_en, r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata, r_mem_wmask;

  logic              w_grant, w_wr_ok, w_accept, w_in_range;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata, w_wmask;
  logic              w_mem_en, w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata, w_mem_wmask;

  // A lone requester wins outright; the pointer only breaks ties.
  assign w_grant    = (bus.w0_valid && bus.w1_valid) ? r_rr : bus.w1_valid;
  assign w_wr_ok    = !rst && w_idle && !bus.scan_req;
  assign bus.w0_ready = w_wr_ok && bus.w0_valid && !w_grant;
  assign bus.w1_ready = w_wr_ok && bus.w1_valid && w_grant;
  assign w_accept   = bus.w0_ready || bus.w1_ready;
  assign w_waddr    = w_grant ? bus.w1_addr : bus.w0_addr;
  assign w_wdata    = w_grant ? bus.w1_data : bus.w0_data;
  assign w_wmask    = w_grant ? bus.w1_mask : bus.w0_mask;
  assign w_in_range = (w_waddr < c_words);

  always_comb begin
    w_mem_en    = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    w_mem_wmask = '0;
    if (bus.scan_req) begin
      w_mem_en   = 1'b1;
      w_mem_addr = bus.scan_addr;
    end else if (w_clearing) begin
      w_mem_en    = 1'b1;
      w_mem_we    = 1'b1;
      w_mem_addr  = w_clr_addr;
      w_mem_wdata = w_clr_data;
      w_mem_wmask = '1;
    end else if (w_accept && w_in_range) begin
      w_mem_en    = 1'b1;
      w_mem_we    = 1'b1;
      w_mem_addr  = w_waddr;
      w_mem_wdata = w_wdata;
      w_mem_wmask = w_wmask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr         <= 1'b0;
      r_addr_err   <= 1'b0;
      r_scan_p1    <= 1'b0;
      r_scan_valid <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_wmask  <= '0;
    end else begin
      r_scan_p1    <= bus.scan_req;
      r_scan_valid <= r_scan_p1;
      r_mem_en     <= w_mem_en;
      r_mem_we     <= w_mem_we;
      r_mem_addr   <= w_mem_addr;
      r_mem_wdata  <= w_mem_wdata;
      r_mem_wmask  <= w_mem_wmask;
      if (w_accept) begin
        r_rr <= ~w_grant;
        if (!w_in_range) r_addr_err <= 1'b1;
      end
    end
  end

  assign bus.mem_en     = r_mem_en;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.mem_wmask  = r_mem_wmask;
  assign bus.addr_err   = r_addr_err;
  assign bus.scan_valid = r_scan_valid;
  // RAM data arrives one cycle after the registered read strobe; pass it through.
  assign bus.scan_data  = r_scan_valid ? bus.mem_rdata : '0;
endmodule
`default_nettype wire

// File: tb/tb_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_fb_arbiter
// Brief   : Directed self-checking bench for fb_arbiter with a behavioural
//           synchronous RAM model preloaded with word = address.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fb_arbiter_if #(.ADDR_W(13), .DATA_W(16)) bus ();
  fb_arbiter #(.ADDR_W(13), .DATA_W(16), .WORDS(4800)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] ram [0:8191];
  initial begin
    for (int i = 0; i < 8192; i++) ram[i] = 16'(i);
    bus.mem_rdata = 16'h0;
    forever begin
      @(posedge clk);
      if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= ram[bus.mem_addr];
      if (bus.mem_en && bus.mem_we)
        ram[bus.mem_addr] = (ram[bus.mem_addr] & ~bus.mem_wmask) | (bus.mem_wdata & bus.mem_wmask);
    end
  end

  task automatic idle_inputs();
    bus.scan_req = 0; bus.scan_addr = 0;
    bus.w0_valid = 0; bus.w0_addr = 0; bus.w0_data = 0; bus.w0_mask = 0;
    bus.w1_valid = 0; bus.w1_addr = 0; bus.w1_data = 0; bus.w1_mask = 0;
    bus.clear_start = 0; bus.clear_value = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    bus.w0_valid = 1; bus.w1_valid = 1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({bus.w1_ready, bus.w0_ready} !== 2'b00) begin
      failures++; $display("FAIL reset_ready got=%b exp=00", {bus.w1_ready, bus.w0_ready});
    end
    checks++;
    if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wmask} !== 47'h0) begin
      failures++; $display("FAIL reset_mem en=%b we=%b addr=%0d exp all zero", bus.mem_en, bus.mem_we, bus.mem_addr);
    end
    checks++;
    if ({bus.scan_valid, bus.scan_data, bus.clear_busy, bus.addr_err} !== 19'h0) begin
      failures++; $display("FAIL reset_status valid=%b data=%h busy=%b err=%b exp all zero",
                           bus.scan_valid, bus.scan_data, bus.clear_busy, bus.addr_err);
    end
    idle_inputs();
    rst = 0;
  endtask

  task automatic test_scan();
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      checks++;
      if (k >= 2 && k <= 21) begin
        if (bus.scan_valid !== 1'b1 || bus.scan_data !== 16'(k - 2)) begin
          failures++; $display("FAIL scan_data k=%0d got valid=%b data=%h exp valid=1 data=%h",
                               k, bus.scan_valid, bus.scan_data, 16'(k - 2));
        end
      end else if (bus.scan_valid !== 1'b0) begin
        failures++; $display("FAIL scan_idle k=%0d got valid=%b exp 0", k, bus.scan_valid);
      end
      if (k == 1) begin
        checks++;
        if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 13'd0) begin
          failures++; $display("FAIL scan_mem got en=%b we=%b addr=%0d exp en=1 we=0 addr=0",
                               bus.mem_en, bus.mem_we, bus.mem_addr);
        end
      end
      bus.scan_req  = (k < 20);
      bus.scan_addr = 13'(k);
    end
    bus.scan_req = 0;
  endtask

  task automatic test_round_robin();
    bus.w0_addr = 13'd10; bus.w0_data = 16'h1111; bus.w0_mask = 16'hFFFF;
    bus.w1_addr = 13'd20; bus.w1_data = 16'h2222; bus.w1_mask = 16'hFFFF;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      if (j > 0) begin
        checks++;
        if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 ||
            bus.mem_addr !== (((j - 1) % 2 == 0) ? 13'd10 : 13'd20) ||
            bus.mem_wdata !== (((j - 1) % 2 == 0) ? 16'h1111 : 16'h2222)) begin
          failures++; $display("FAIL rr_mem j=%0d got en=%b we=%b addr=%0d data=%h", j,
                               bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
      end
      if (j < 4) begin
        bus.w0_valid = 1; bus.w1_valid = 1;
        #1;
        checks++;
        if ({bus.w1_ready, bus.w0_ready} !== ((j % 2 == 0) ? 2'b01 : 2'b10)) begin
          failures++; $display("FAIL rr_grant j=%0d got=%b exp=%b", j, {bus.w1_ready, bus.w0_ready},
                               (j % 2 == 0) ? 2'b01 : 2'b10);
        end
      end else begin
        bus.w0_valid = 0; bus.w1_valid = 0;
      end
    end
  endtask

  task automatic test_contention();
    bus.w0_addr = 13'd5; bus.w0_data = 16'hFFFF; bus.w0_mask = 16'hFFFF;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      bus.scan_req = 1; bus.scan_addr = 13'd7; bus.w0_valid = 1;
      #1;
      checks++;
      if (bus.w0_ready !== 1'b0) begin
        failures++; $display("FAIL contention_stall j=%0d got w0_ready=%b exp 0", j, bus.w0_ready);
      end
    end
    @(negedge clk);
    bus.scan_req = 0;
    #1;
    checks++;
    if (bus.w0_ready !== 1'b1) begin
      failures++; $display("FAIL contention_release got w0_ready=%b exp 1", bus.w0_ready);
    end
    @(negedge clk);
    bus.w0_valid = 0;
    checks++;
    if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 13'd5 ||
        bus.mem_wdata !== 16'hFFFF || bus.mem_wmask !== 16'hFFFF) begin
      failures++; $display("FAIL contention_write got en=%b we=%b addr=%0d data=%h mask=%h exp 1 1 5 ffff ffff",
                           bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wmask);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_masked_and_range();
    @(negedge clk);
    bus.w0_valid = 1; bus.w0_addr = 13'd30; bus.w0_data = 16'h00FF; bus.w0_mask = 16'h0F0F;
    @(negedge clk);
    bus.w0_valid = 0;
    checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== 13'd30 || bus.mem_wdata !== 16'h00FF ||
        bus.mem_wmask !== 16'h0F0F) begin
      failures++; $display("FAIL masked_write got we=%b addr=%0d data=%h mask=%h exp 1 30 00ff 0f0f",
                           bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wmask);
    end
    bus.w1_valid = 1; bus.w1_addr = 13'd4800; bus.w1_data = 16'h1234; bus.w1_mask = 16'hFFFF;
    #1;
    checks++;
    if (bus.w1_ready !== 1'b1 || bus.addr_err !== 1'b0) begin
      failures++; $display("FAIL oor_handshake got ready=%b err=%b exp ready=1 err=0", bus.w1_ready, bus.addr_err);
    end
    @(negedge clk);
    bus.w1_valid = 0;
    checks++;
    if (bus.mem_en !== 1'b0 || bus.addr_err !== 1'b1) begin
      failures++; $display("FAIL oor_drop got en=%b err=%b exp en=0 err=1", bus.mem_en, bus.addr_err);
    end
    bus.w0_valid = 1; bus.w0_addr = 13'd4799; bus.w0_data = 16'h5A5A; bus.w0_mask = 16'hFFFF;
    @(negedge clk);
    bus.w0_valid = 0;
    checks++;
    if (bus.mem_en !== 1'b1 || bus.mem_addr !== 13'd4799 || bus.addr_err !== 1'b1) begin
      failures++; $display("FAIL last_word got en=%b addr=%0d err=%b exp en=1 addr=4799 err=1",
                           bus.mem_en, bus.mem_addr, bus.addr_err);
    end
    @(negedge clk);
  endtask

`ifdef FB_ARB_CLEAR_EN
  task automatic test_clear_steals();
    int busy_cnt = 0, nxt = 0, bad = 0, rdy_seen = 0, reads = 0;
    bit done = 0;
    @(negedge clk);
    bus.clear_start = 1; bus.clear_value = 16'hAAAA;
    bus.w0_valid = 1; bus.w0_addr = 13'd40; bus.w0_data = 16'h1234; bus.w0_mask = 16'hFFFF;
    #1;
    checks++;
    if (bus.w0_ready !== 1'b1) begin
      failures++; $display("FAIL clear_same_cycle_write got w0_ready=%b exp 1", bus.w0_ready);
    end
    @(negedge clk);
    bus.clear_start = 0;
    checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== 13'd40 || bus.clear_busy !== 1'b1) begin
      failures++; $display("FAIL clear_entry got we=%b addr=%0d busy=%b exp we=1 addr=40 busy=1",
                           bus.mem_we, bus.mem_addr, bus.clear_busy);
    end
    for (int c = 0; c < 6000; c++) begin
      if (c > 0) begin
        if (bus.mem_en && bus.mem_we) begin
          if (bus.mem_addr !== 13'(nxt) || bus.mem_wdata !== 16'hAAAA || bus.mem_wmask !== 16'hFFFF) bad++;
          nxt++;
        end
        if (bus.mem_en && !bus.mem_we) reads++;
      end
      if (bus.clear_busy) busy_cnt++;
      if (c > 0 && !bus.clear_busy) begin
        done = 1;
        break;
      end
      bus.scan_req = (c inside {5, 6, 7, 8, 9, 1000, 1001, 3000, 3001, 4500});
      #1;
      if (bus.w0_ready !== 1'b0) rdy_seen++;
      @(negedge clk);
    end
    bus.w0_valid = 0; bus.scan_req = 0;
    checks++;
    if (!done) begin
      failures++; $display("FAIL clear_timeout busy never fell within 6000 cycles");
    end
    checks++;
    if (nxt != 4800 || bad != 0) begin
      failures++; $display("FAIL clear_writes got count=%0d bad=%0d exp count=4800 bad=0", nxt, bad);
    end
    checks++;
    if (busy_cnt != 4810) begin
      failures++; $display("FAIL clear_busy_len got=%0d exp=4810", busy_cnt);
    end
    checks++;
    if (rdy_seen != 0 || reads != 10) begin
      failures++; $display("FAIL clear_stall got ready_cycles=%0d reads=%0d exp 0 and 10", rdy_seen, reads);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_clear();
    int writes_after = 0;
    bit hit = 0;
    @(negedge clk);
    bus.clear_start = 1; bus.clear_value = 16'h5555;
    @(negedge clk);
    bus.clear_start = 0;
    for (int c = 0; c < 300; c++) begin
      if (bus.mem_we && bus.mem_addr == 13'd99) begin
        hit = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!hit) begin
      failures++; $display("FAIL midclear_timeout write to 99 not seen");
    end
    rst = 1;
    @(negedge clk);
    checks++;
    if (bus.clear_busy !== 1'b0 || bus.mem_en !== 1'b0 || bus.addr_err !== 1'b0) begin
      failures++; $display("FAIL midclear_reset got busy=%b en=%b err=%b exp 0 0 0",
                           bus.clear_busy, bus.mem_en, bus.addr_err);
    end
    rst = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.mem_en || bus.clear_busy) writes_after++;
    end
    checks++;
    if (writes_after != 0) begin
      failures++; $display("FAIL midclear_quiet got active_cycles=%0d exp 0", writes_after);
    end
  endtask
`else
  task automatic test_clear_disabled();
    int active = 0;
    @(negedge clk);
    bus.clear_start = 1; bus.clear_value = 16'hAAAA;
    @(negedge clk);
    bus.clear_start = 0;
    bus.w0_valid = 1; bus.w0_addr = 13'd50; bus.w0_data = 16'h0F0F; bus.w0_mask = 16'hFFFF;
    #1;
    checks++;
    if (bus.w0_ready !== 1'b1) begin
      failures++; $display("FAIL noclear_write got w0_ready=%b exp 1", bus.w0_ready);
    end
    @(negedge clk);
    bus.w0_valid = 0;
    checks++;
    if (bus.mem_addr !== 13'd50 || bus.mem_wdata !== 16'h0F0F) begin
      failures++; $display("FAIL noclear_mem got addr=%0d data=%h exp 50 0f0f", bus.mem_addr, bus.mem_wdata);
    end
    repeat (20) begin
      @(negedge clk);
      if (bus.mem_en || bus.clear_busy) active++;
    end
    checks++;
    if (active != 0) begin
      failures++; $display("FAIL noclear_quiet got active_cycles=%0d exp 0", active);
    end
    rst = 1;
    @(negedge clk);
    rst = 0;
    checks++;
    if (bus.addr_err !== 1'b0) begin
      failures++; $display("FAIL err_cleared got=%b exp 0", bus.addr_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_scan();
    test_round_robin();
    test_contention();
    test_masked_and_range();
`ifdef FB_ARB_CLEAR_EN
    test_clear_steals();
    test_reset_mid_clear();
`else
    test_clear_disabled();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
